// File: rtl/tpu_ctrl_pkg.sv
// Shared constants, FSM state encoding and the sequencer-to-address-generator
// control bundle for the TPU matmul controller.
package tpu_ctrl_pkg;

  localparam int unsigned AS_DEFAULT    = 4;
  localparam int unsigned ADDR_W_DEFAULT = 10;
  localparam int unsigned DRAIN_DEFAULT = 2 * AS_DEFAULT - 1;
  localparam int unsigned DIM_W         = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_e;

  typedef struct packed {
    logic load;
    logic clear;
    logic feed;
    logic write;
  } agen_ctl_t;

  function automatic logic [DIM_W-1:0] tile_count(input logic [DIM_W-1:0] dim,
                                                  input int unsigned edge_len);
    int unsigned tiles;
    tiles = (int'(dim) + edge_len - 1) / edge_len;
    return DIM_W'(tiles);
  endfunction

endpackage

// File: rtl/tpu_tile_addr_gen.sv
// Tile/operand/row counters and the GBUFF_A/B/OUT index arithmetic.
// Indices are live while their phase is active and hold their last value otherwise.
module tpu_tile_addr_gen
  import tpu_ctrl_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  agen_ctl_t                     ctl,
  input  logic [DIM_W-1:0]              m,
  input  logic [DIM_W-1:0]              k,
  input  logic [DIM_W-1:0]              n,
  output logic [ADDR_W-1:0]             index_a,
  output logic [ADDR_W-1:0]             index_b,
  output logic [ADDR_W-1:0]             index_o,
  output logic [$clog2(ARRAY_SIZE)-1:0] row_sel,
  output logic                          kk_last,
  output logic                          r_last,
  output logic                          tile_last
);

  localparam int unsigned RW = $clog2(ARRAY_SIZE);

  logic [DIM_W-1:0]  t, u, kk;
  logic [RW-1:0]     r;
  logic [DIM_W-1:0]  mt, nt;
  logic [DIM_W:0]    rows_left;
  logic [DIM_W:0]    r_next;
  logic [ADDR_W-1:0] addr_a, addr_b, addr_o;
  logic [ADDR_W-1:0] hold_a, hold_b, hold_o;

  always_comb begin
    mt        = tile_count(m, ARRAY_SIZE);
    nt        = tile_count(n, ARRAY_SIZE);
    rows_left = {1'b0, m} - (DIM_W+1)'(int'(t) * ARRAY_SIZE);
    r_next    = (DIM_W+1)'(r) + (DIM_W+1)'(1);
    kk_last   = (kk == k - 1'b1);
    // Last row of the tile: array edge reached, or the bottom partial tile ran out of rows.
    r_last    = (r == RW'(ARRAY_SIZE - 1)) || (r_next == rows_left);
    tile_last = (t == mt - 1'b1) && (u == nt - 1'b1);

    addr_a = ADDR_W'(t) * ADDR_W'(k) + ADDR_W'(kk);
    addr_b = ADDR_W'(u) * ADDR_W'(k) + ADDR_W'(kk);
    addr_o = ADDR_W'(u) * ADDR_W'(m) + ADDR_W'(int'(t) * ARRAY_SIZE) + ADDR_W'(r);

    index_a = ctl.feed  ? addr_a : hold_a;
    index_b = ctl.feed  ? addr_b : hold_b;
    index_o = ctl.write ? addr_o : hold_o;
    row_sel = r;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t      <= '0;
      u      <= '0;
      kk     <= '0;
      r      <= '0;
      hold_a <= '0;
      hold_b <= '0;
      hold_o <= '0;
    end else begin
      if (ctl.load) begin
        t  <= '0;
        u  <= '0;
        kk <= '0;
        r  <= '0;
      end
      if (ctl.clear) begin
        kk <= '0;
        r  <= '0;
      end
      if (ctl.feed) begin
        kk     <= kk + 1'b1;
        hold_a <= addr_a;
        hold_b <= addr_b;
      end
      if (ctl.write) begin
        hold_o <= addr_o;
        if (r_last) begin
          r <= '0;
          // u is the inner tile loop; wrapping it advances the row-tile t.
          if (u == nt - 1'b1) begin
            u <= '0;
            t <= t + 1'b1;
          end else begin
            u <= u + 1'b1;
          end
        end else begin
          r <= r + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tpu_ctrl.sv
// Sequencer for the TPU matrix-multiply datapath: tiles C = A*B and walks each
// tile through clear, operand feed, pipeline drain and row write-back.
module tpu_ctrl
  import tpu_ctrl_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = AS_DEFAULT,
  parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
  parameter int unsigned DRAIN_CYC  = DRAIN_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [3:0]                    m,
  input  logic [3:0]                    k,
  input  logic [3:0]                    n,
  output logic                          done,
  output logic                          busy,
  output logic                          wr_en_a,
  output logic                          wr_en_b,
  output logic [ADDR_W-1:0]             index_a,
  output logic [ADDR_W-1:0]             index_b,
  output logic                          wr_en_o,
  output logic [ADDR_W-1:0]             index_o,
  output logic                          pe_clear,
  output logic                          pe_valid,
  output logic [$clog2(ARRAY_SIZE)-1:0] row_sel
);

  localparam int unsigned DW = $clog2(DRAIN_CYC + 1);

  state_e           state, next_state;
  agen_ctl_t        ctl;
  logic [DIM_W-1:0] m_q, k_q, n_q;
  logic [DW-1:0]    dcnt;
  logic             feed_d, done_q;
  logic             accept, dims_zero;
  logic             kk_last, r_last, tile_last;

  assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
  assign dims_zero = (m == '0) || (k == '0) || (n == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE, S_DONE: if (accept) next_state = dims_zero ? S_DONE : S_CLEAR;
      S_CLEAR:        next_state = S_FEED;
      S_FEED:         if (kk_last) next_state = S_DRAIN;
      S_DRAIN:        if (dcnt == DW'(DRAIN_CYC - 1)) next_state = S_WRITE;
      S_WRITE:        if (r_last) next_state = tile_last ? S_DONE : S_CLEAR;
      default:        next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ctl.load  = accept && !dims_zero;
    ctl.clear = (state == S_CLEAR);
    ctl.feed  = (state == S_FEED);
    ctl.write = (state == S_WRITE);
    pe_clear  = (state == S_CLEAR);
    wr_en_o   = (state == S_WRITE);
    busy      = (state == S_CLEAR) || (state == S_FEED) ||
                (state == S_DRAIN) || (state == S_WRITE);
    done      = done_q;
    pe_valid  = feed_d;
    wr_en_a   = 1'b0;
    wr_en_b   = 1'b0;
  end

  // Dims, drain counter, read-latency-matched valid and the registered done flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q    <= '0;
      k_q    <= '0;
      n_q    <= '0;
      dcnt   <= '0;
      feed_d <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (accept) begin
        m_q <= m;
        k_q <= k;
        n_q <= n;
      end
      if (state == S_DRAIN) dcnt <= dcnt + 1'b1;
      else                  dcnt <= '0;
      feed_d <= (state == S_FEED);
      done_q <= (state == S_DONE);
    end
  end

  tpu_tile_addr_gen #(
    .ARRAY_SIZE (ARRAY_SIZE),
    .ADDR_W     (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .ctl       (ctl),
    .m         (m_q),
    .k         (k_q),
    .n         (n_q),
    .index_a   (index_a),
    .index_b   (index_b),
    .index_o   (index_o),
    .row_sel   (row_sel),
    .kk_last   (kk_last),
    .r_last    (r_last),
    .tile_last (tile_last)
  );

endmodule
